// File: rtl/pwm_sample_sequencer_if.sv
// ADC start/done handshake plus AXI-Stream result beat for pwm_sample_sequencer.
// master = sequencer side, slave = ADC driver / FOC datapath side.
interface pwm_sample_sequencer_if #(
  parameter int NUM_CH    = 3,
  parameter int ADC_WIDTH = 12,
  parameter int CH_W      = 3
);
  logic                        adc_start;
  logic [CH_W-1:0]             adc_ch;
  logic                        adc_done;
  logic [ADC_WIDTH-1:0]        adc_data;
  logic [NUM_CH*ADC_WIDTH-1:0] m_axis_tdata;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;

  modport master (
    output adc_start, adc_ch, m_axis_tdata, m_axis_tvalid,
    input  adc_done, adc_data, m_axis_tready
  );

  modport slave (
    input  adc_start, adc_ch, m_axis_tdata, m_axis_tvalid,
    output adc_done, adc_data, m_axis_tready
  );
endinterface

// File: rtl/pwm_sample_sequencer.sv
// PWM-synchronous ADC sequencer: one trigger -> NUM_CH conversions -> one AXI-Stream beat.
// Optional SAMPLE_SEQ_OVERSAMPLE_EN: two conversions per channel, slot holds their floor average.
module pwm_sample_sequencer #(
  parameter int NUM_CH    = 3,
  parameter int ADC_WIDTH = 12,
  parameter int CH_W      = 3,
  parameter int TIMEOUT   = 200,
  parameter int TMR_W     = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic trig,
  input  logic fault_clr,
  output logic overrun,
  output logic fault,
  pwm_sample_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam int                DW       = NUM_CH * ADC_WIDTH;
  localparam logic [CH_W-1:0]   LAST_IDX = CH_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0]  TMO_LAST = TMR_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CH_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [DW-1:0]    tdata_q, tdata_d;
  logic             overrun_q, overrun_d;
  logic             fault_q, fault_d;
  logic             timeout_hit;

`ifdef SAMPLE_SEQ_OVERSAMPLE_EN
  logic                 pass_q, pass_d;
  logic [ADC_WIDTH-1:0] first_q, first_d;

  function automatic logic [ADC_WIDTH-1:0] avg2(input logic [ADC_WIDTH-1:0] a,
                                                input logic [ADC_WIDTH-1:0] b);
    logic [ADC_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[ADC_WIDTH:1];
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    tdata_d     = tdata_q;
    timeout_hit = 1'b0;
    overrun_d   = trig && (state_q != S_IDLE);
`ifdef SAMPLE_SEQ_OVERSAMPLE_EN
    pass_d      = pass_q;
    first_d     = first_q;
`endif

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
`ifdef SAMPLE_SEQ_OVERSAMPLE_EN
        pass_d  = 1'b0;
`endif
        if (trig && !fault_q) begin
          state_d = S_START;
          idx_d   = '0;
        end
      end
      // timer counts from the START cycle, so the window is measured from adc_start
      S_START: begin
        timer_d = timer_q + 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.adc_done) begin
          timer_d = '0;
`ifdef SAMPLE_SEQ_OVERSAMPLE_EN
          if (!pass_q) begin
            first_d = bus.adc_data;
            pass_d  = 1'b1;
            state_d = S_START;
          end else begin
            pass_d = 1'b0;
            tdata_d[int'(idx_q)*ADC_WIDTH +: ADC_WIDTH] = avg2(first_q, bus.adc_data);
            if (idx_q == LAST_IDX) begin
              state_d = S_OUT;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_START;
            end
          end
`else
          tdata_d[int'(idx_q)*ADC_WIDTH +: ADC_WIDTH] = bus.adc_data;
          if (idx_q == LAST_IDX) begin
            state_d = S_OUT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_START;
          end
`endif
        end else if (timer_q == TMO_LAST) begin
          // partial frame is abandoned; slots keep whatever was captured
          timeout_hit = 1'b1;
          timer_d     = '0;
          idx_d       = '0;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_OUT: begin
        if (bus.m_axis_tready) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        timer_d = '0;
      end
    endcase

    if (fault_clr) begin
      fault_d = 1'b0;
    end else if (timeout_hit) begin
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      tdata_q   <= '0;
      overrun_q <= 1'b0;
      fault_q   <= 1'b0;
`ifdef SAMPLE_SEQ_OVERSAMPLE_EN
      pass_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      tdata_q   <= tdata_d;
      overrun_q <= overrun_d;
      fault_q   <= fault_d;
`ifdef SAMPLE_SEQ_OVERSAMPLE_EN
      pass_q    <= pass_d;
`endif
    end
  end

`ifdef SAMPLE_SEQ_OVERSAMPLE_EN
  always_ff @(posedge clk) begin
    first_q <= first_d;
  end
`endif

  assign bus.adc_start     = (state_q == S_START);
  assign bus.adc_ch        = idx_q;
  assign bus.m_axis_tvalid = (state_q == S_OUT);
  assign bus.m_axis_tdata  = tdata_q;
  assign overrun           = overrun_q;
  assign fault             = fault_q;

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Directed bench for pwm_sample_sequencer (default build, NUM_CH=3, TIMEOUT=200).
// A small ADC responder answers each adc_start after adc_d cycles from a per-channel table.
module tb_pwm_sample_sequencer;
  localparam int NUM_CH    = 3;
  localparam int ADC_WIDTH = 12;
  localparam int CH_W      = 3;
  localparam int TIMEOUT   = 200;
  localparam int TMR_W     = 16;
  localparam int DW        = NUM_CH * ADC_WIDTH;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic trig = 1'b0;
  logic fault_clr = 1'b0;
  logic overrun, fault;

  pwm_sample_sequencer_if #(.NUM_CH(NUM_CH), .ADC_WIDTH(ADC_WIDTH), .CH_W(CH_W)) bus_if ();

  pwm_sample_sequencer #(
    .NUM_CH(NUM_CH), .ADC_WIDTH(ADC_WIDTH), .CH_W(CH_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)
  ) dut (
    .clk(clk), .rstn(rstn), .trig(trig), .fault_clr(fault_clr),
    .overrun(overrun), .fault(fault), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // ADC responder state
  int             adc_d = 4;
  logic [11:0]    resp [8];
  int             drop_ch = 8;
  int             start_cnt = 0;
  int             start_cyc [16];
  logic [CH_W-1:0] ch_log [16];
  int             b2b = 0;
  int             pend = 0;
  logic [11:0]    pend_val = '0;
  logic           prev_start = 1'b0;

  initial begin
    bus_if.adc_done = 1'b0;
    bus_if.adc_data = '0;
    forever begin
      @(negedge clk);
      bus_if.adc_done = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          bus_if.adc_done = 1'b1;
          bus_if.adc_data = pend_val;
        end
      end
      if (bus_if.adc_start === 1'b1) begin
        if (prev_start) b2b = b2b + 1;
        start_cyc[start_cnt % 16] = cyc;
        ch_log[start_cnt % 16]    = bus_if.adc_ch;
        start_cnt = start_cnt + 1;
        if (int'(bus_if.adc_ch) != drop_ch) begin
          pend     = adc_d;
          pend_val = resp[bus_if.adc_ch];
        end
      end
      prev_start = (bus_if.adc_start === 1'b1);
    end
  end

  task automatic test_reset();
    rstn = 1'b0;
    bus_if.m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus_if.adc_start !== 1'b0) begin miscompares++; $display("FAIL reset_adc_start: got %b want 0", bus_if.adc_start); end
    vectors++; if (bus_if.adc_ch !== 3'd0) begin miscompares++; $display("FAIL reset_adc_ch: got %h want 0", bus_if.adc_ch); end
    vectors++; if (bus_if.m_axis_tdata !== 36'h0) begin miscompares++; $display("FAIL reset_tdata: got %h want 0", bus_if.m_axis_tdata); end
    vectors++; if (bus_if.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", bus_if.m_axis_tvalid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", fault); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (bus_if.adc_start !== 1'b0) begin miscompares++; $display("FAIL idle_no_start: got %b want 0", bus_if.adc_start); end
  endtask

  task automatic test_basic_frame();
    int base, t0, first, beats, ovs;
    logic [DW-1:0] cap;
    resp[0] = 12'h111; resp[1] = 12'h222; resp[2] = 12'h333;
    bus_if.m_axis_tready = 1'b1;
    base = start_cnt; first = -1; beats = 0; ovs = 0; cap = '0;
    @(negedge clk);
    trig = 1'b1; t0 = cyc;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      trig = 1'b0;
      if (overrun) ovs++;
      if (bus_if.m_axis_tvalid) begin
        beats++;
        if (first < 0) begin first = cyc - t0; cap = bus_if.m_axis_tdata; end
      end
    end
    vectors++; if (first !== 16) begin miscompares++; $display("FAIL basic_latency: got %0d want 16", first); end
    vectors++; if (beats !== 1) begin miscompares++; $display("FAIL basic_beats: got %0d want 1", beats); end
    vectors++; if (cap !== 36'h333222111) begin miscompares++; $display("FAIL basic_tdata: got %h want 333222111", cap); end
    vectors++; if (start_cnt - base !== 3) begin miscompares++; $display("FAIL basic_starts: got %0d want 3", start_cnt - base); end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (ch_log[(base + k) % 16] !== CH_W'(k)) begin
        miscompares++; $display("FAIL basic_ch%0d: got %0d want %0d", k, ch_log[(base + k) % 16], k);
      end
    end
    vectors++; if (ovs !== 0) begin miscompares++; $display("FAIL basic_overrun: got %0d pulses want 0", ovs); end
    vectors++; if (b2b !== 0) begin miscompares++; $display("FAIL start_back_to_back: got %0d want 0", b2b); end
  endtask

  task automatic test_backpressure();
    int base, t0, first, held, vb;
    logic [DW-1:0] cap;
    resp[0] = 12'h0AB; resp[1] = 12'hFFF; resp[2] = 12'h000;
    bus_if.m_axis_tready = 1'b0;
    base = start_cnt; first = -1; held = 0; vb = 0; cap = '0;
    @(negedge clk);
    trig = 1'b1; t0 = cyc;
    for (int i = 1; i <= 40 && first < 0; i++) begin
      @(negedge clk);
      trig = 1'b0;
      if (bus_if.m_axis_tvalid) begin first = cyc - t0; cap = bus_if.m_axis_tdata; end
    end
    vectors++; if (first !== 16) begin miscompares++; $display("FAIL bp_latency: got %0d want 16", first); end
    vectors++; if (cap !== 36'h000FFF0AB) begin miscompares++; $display("FAIL bp_tdata: got %h want 000fff0ab", cap); end
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (bus_if.m_axis_tvalid === 1'b1 && bus_if.m_axis_tdata === 36'h000FFF0AB) held++;
    end
    vectors++; if (held !== 19) begin miscompares++; $display("FAIL bp_hold: got %0d stable cycles want 19", held); end
    @(negedge clk);
    vectors++; if (bus_if.m_axis_tvalid !== 1'b1) begin miscompares++; $display("FAIL bp_still_valid: got %b want 1", bus_if.m_axis_tvalid); end
    bus_if.m_axis_tready = 1'b1;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    vectors++; if (bus_if.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL bp_accept: tvalid got %b want 0", bus_if.m_axis_tvalid); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL bp_out_trig_overrun: got %b want 1", overrun); end
    @(negedge clk);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL bp_overrun_width: got %b want 0", overrun); end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus_if.m_axis_tvalid) vb++;
    end
    vectors++; if (start_cnt - base !== 3) begin miscompares++; $display("FAIL bp_no_rearm: got %0d starts want 3", start_cnt - base); end
    vectors++; if (vb !== 0) begin miscompares++; $display("FAIL bp_extra_beat: got %0d want 0", vb); end
  endtask

  task automatic test_overrun();
    int base, t0, ov_cnt, ov_first, beats;
    logic [DW-1:0] cap;
    resp[0] = 12'h5A5; resp[1] = 12'h3C3; resp[2] = 12'h001;
    bus_if.m_axis_tready = 1'b1;
    base = start_cnt; ov_cnt = 0; ov_first = -1; beats = 0; cap = '0;
    @(negedge clk);
    trig = 1'b1; t0 = cyc;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      trig = (i == 5);
      if (overrun) begin ov_cnt++; if (ov_first < 0) ov_first = cyc - t0; end
      if (bus_if.m_axis_tvalid) begin beats++; cap = bus_if.m_axis_tdata; end
    end
    trig = 1'b0;
    vectors++; if (ov_cnt !== 1) begin miscompares++; $display("FAIL ov_pulses: got %0d want 1", ov_cnt); end
    vectors++; if (ov_first !== 6) begin miscompares++; $display("FAIL ov_cycle: got %0d want 6", ov_first); end
    vectors++; if (start_cnt - base !== 3) begin miscompares++; $display("FAIL ov_starts: got %0d want 3", start_cnt - base); end
    vectors++; if (beats !== 1) begin miscompares++; $display("FAIL ov_beats: got %0d want 1", beats); end
    vectors++; if (cap !== 36'h0013C35A5) begin miscompares++; $display("FAIL ov_tdata: got %h want 0013c35a5", cap); end
  endtask

  task automatic test_timeout();
    int base, s1, fdelta, vb, ovs, first, t0, fhi;
    logic [DW-1:0] cap;
    resp[0] = 12'h010; resp[1] = 12'h020; resp[2] = 12'h030;
    bus_if.m_axis_tready = 1'b1;
    drop_ch = 1;
    base = start_cnt; fdelta = -1; vb = 0;
    @(negedge clk);
    trig = 1'b1;
    for (int i = 0; i < 50 && start_cnt < base + 2; i++) begin
      @(negedge clk);
      trig = 1'b0;
    end
    trig = 1'b0;
    s1 = start_cyc[(base + 1) % 16];
    for (int i = 0; i < 300 && fdelta < 0; i++) begin
      @(negedge clk);
      if (bus_if.m_axis_tvalid) vb++;
      if (fault) fdelta = cyc - s1;
    end
    vectors++; if (fdelta !== 200) begin miscompares++; $display("FAIL tmo_fault_cycle: got %0d want 200", fdelta); end
    vectors++; if (vb !== 0) begin miscompares++; $display("FAIL tmo_no_beat: got %0d want 0", vb); end
    vectors++; if (start_cnt - base !== 2) begin miscompares++; $display("FAIL tmo_starts: got %0d want 2", start_cnt - base); end
    // trigger while faulted: no start, no overrun
    base = start_cnt; ovs = 0;
    trig = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      trig = 1'b0;
      if (overrun) ovs++;
    end
    vectors++; if (start_cnt - base !== 0) begin miscompares++; $display("FAIL tmo_trig_ignored: got %0d starts want 0", start_cnt - base); end
    vectors++; if (ovs !== 0) begin miscompares++; $display("FAIL tmo_trig_overrun: got %0d want 0", ovs); end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky: got %b want 1", fault); end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL tmo_clear: got %b want 0", fault); end
    // recovery frame
    drop_ch = 8;
    resp[0] = 12'h456; resp[1] = 12'h789; resp[2] = 12'hABC;
    first = -1; cap = '0;
    @(negedge clk);
    trig = 1'b1; t0 = cyc;
    for (int i = 1; i <= 40 && first < 0; i++) begin
      @(negedge clk);
      trig = 1'b0;
      if (bus_if.m_axis_tvalid) begin first = cyc - t0; cap = bus_if.m_axis_tdata; end
    end
    vectors++; if (first !== 16) begin miscompares++; $display("FAIL tmo_recover_latency: got %0d want 16", first); end
    vectors++; if (cap !== 36'hABC789456) begin miscompares++; $display("FAIL tmo_recover_tdata: got %h want abc789456", cap); end
    // fault_clr held through a timeout wins over the fault set
    repeat (3) @(negedge clk);
    drop_ch = 0; fhi = 0;
    fault_clr = 1'b1;
    trig = 1'b1;
    for (int i = 0; i < 230; i++) begin
      @(negedge clk);
      trig = 1'b0;
      if (fault) fhi++;
    end
    fault_clr = 1'b0;
    @(negedge clk);
    vectors++; if (fhi !== 0) begin miscompares++; $display("FAIL clr_priority: fault high %0d cycles want 0", fhi); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL clr_priority_after: got %b want 0", fault); end
    drop_ch = 8;
    resp[0] = 12'h001; resp[1] = 12'h002; resp[2] = 12'h003;
    first = -1; ovs = 0; cap = '0;
    trig = 1'b1; t0 = cyc;
    for (int i = 1; i <= 40 && first < 0; i++) begin
      @(negedge clk);
      trig = 1'b0;
      if (overrun) ovs++;
      if (bus_if.m_axis_tvalid) begin first = cyc - t0; cap = bus_if.m_axis_tdata; end
    end
    vectors++; if (ovs !== 0) begin miscompares++; $display("FAIL clr_idle_overrun: got %0d want 0", ovs); end
    vectors++; if (cap !== 36'h003002001) begin miscompares++; $display("FAIL clr_frame_tdata: got %h want 003002001", cap); end
  endtask

  task automatic test_reset_mid_wait();
    int base, s1, vb, first;
    logic [DW-1:0] cap;
    resp[0] = 12'h321; resp[1] = 12'h654; resp[2] = 12'h987;
    bus_if.m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    base = start_cnt;
    trig = 1'b1;
    for (int i = 0; i < 50 && start_cnt < base + 2; i++) begin
      @(negedge clk);
      trig = 1'b0;
    end
    trig = 1'b0;
    s1 = start_cyc[(base + 1) % 16];
    for (int i = 0; i < 10 && cyc < s1 + 2; i++) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    vectors++; if (bus_if.adc_start !== 1'b0) begin miscompares++; $display("FAIL rmw_adc_start: got %b want 0", bus_if.adc_start); end
    vectors++; if (bus_if.adc_ch !== 3'd0) begin miscompares++; $display("FAIL rmw_adc_ch: got %h want 0", bus_if.adc_ch); end
    vectors++; if (bus_if.m_axis_tdata !== 36'h0) begin miscompares++; $display("FAIL rmw_tdata: got %h want 0", bus_if.m_axis_tdata); end
    vectors++; if (bus_if.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rmw_tvalid: got %b want 0", bus_if.m_axis_tvalid); end
    vectors++; if (overrun !== 1'b0 || fault !== 1'b0) begin miscompares++; $display("FAIL rmw_flags: got overrun=%b fault=%b want 0 0", overrun, fault); end
    vb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_if.m_axis_tvalid) vb++;
    end
    vectors++; if (vb !== 0 || start_cnt - base !== 2) begin miscompares++; $display("FAIL rmw_late_done: beats=%0d starts=%0d want 0 and 2", vb, start_cnt - base); end
    vectors++; if (bus_if.m_axis_tdata !== 36'h0) begin miscompares++; $display("FAIL rmw_late_done_tdata: got %h want 0", bus_if.m_axis_tdata); end
    first = -1; cap = '0;
    trig = 1'b1;
    for (int i = 1; i <= 40 && first < 0; i++) begin
      @(negedge clk);
      trig = 1'b0;
      if (bus_if.m_axis_tvalid) begin first = i; cap = bus_if.m_axis_tdata; end
    end
    vectors++; if (ch_log[(base + 2) % 16] !== 3'd0) begin miscompares++; $display("FAIL rmw_restart_ch: got %0d want 0", ch_log[(base + 2) % 16]); end
    vectors++; if (cap !== 36'h987654321) begin miscompares++; $display("FAIL rmw_frame_tdata: got %h want 987654321", cap); end
  endtask

  initial begin
    bus_if.m_axis_tready = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_overrun();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
